niosii_usb_cpu_cpu_debug_mem_access: RTL and testbench
======================================================

# niosii_USB_cpu_cpu_debug_mem_access

Debug memory access sequencer sitting directly downstream of the debug slave's system-clock stage. It consumes the `jdo` shift-register snapshot and the `take_action_ocimem_*` / `take_no_action_ocimem_a` pulses, then runs the requested read or write against the CPU's on-chip debug RAM through a single Avalon-MM master port. Results return to the debug slave as `MonDReg`, `monitor_ready` and `monitor_error`, which are captured and shifted out over JTAG.

## Interface
Parameters:
- `ADDR_W`, 8, word-address width of the debug RAM.
- `TIMEOUT_CYC`, 255, maximum wait in any memory-wait state (used only when the timeout is compiled in; must be below 2^16).

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock, same clock as the debug slave sysclk stage.
- `reset`  in  1  synchronous, active-high reset.
- `jdo`  in  38  command payload, stable while any take pulse is high.
- `take_action_ocimem_a`  in  1  one-cycle pulse: load address; optionally read.
- `take_no_action_ocimem_a`  in  1  one-cycle pulse: read at the current address.
- `take_action_ocimem_b`  in  1  one-cycle pulse: write at the current address.
- `mem_address`  out  ADDR_W  word address.
- `mem_read`  out  1  Avalon read request.
- `mem_write`  out  1  Avalon write request.
- `mem_writedata`  out  32  write data.
- `mem_readdata`  in  32  read data, valid when `mem_readdatavalid` is high.
- `mem_waitrequest`  in  1  slave stall.
- `mem_readdatavalid`  in  1  read-data strobe.
- `MonDReg`  out  32  last read data.
- `monitor_ready`  out  1  last command completed.
- `monitor_error`  out  1  sticky error flag.
- `busy`  out  1  state is not IDLE.

## Operation
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ.
- Command decode in IDLE:
  - `take_action_ocimem_a`: `addr <= jdo[ADDR_W+16:17]`. If `jdo[34]`=1, go to RD_REQ at the new address. Otherwise address load only; `monitor_ready` stays unchanged.
  - `take_no_action_ocimem_a`: go to RD_REQ at the current `addr`.
  - `take_action_ocimem_b`: `wdata <= jdo[34:3]`, then go to WR_REQ.
- Accepting a command clears `monitor_ready`. `monitor_error` clears only on accepting `take_action_ocimem_a`.
- RD_REQ: `mem_read`=1 and held until a cycle with `mem_waitrequest`=0, then go to RD_WAIT.
- RD_WAIT: on `mem_readdatavalid`, set `MonDReg <= mem_readdata`, set `monitor_ready` to 1, `addr <= addr+1`, and return to IDLE.
- WR_REQ: `mem_write`=1 and held until `mem_waitrequest`=0, then set `monitor_ready` to 1, `addr <= addr+1`, and return to IDLE.
- Address increments modulo 2^ADDR_W; 0xFF wraps to 0x00 at the default width.
- `mem_readdatavalid` is ignored outside RD_WAIT.
- Simultaneous pulses: priority is `take_action_ocimem_a` > `take_action_ocimem_b` > `take_no_action_ocimem_a`. Each losing pulse sets `monitor_error`.
- A pulse arriving while `busy`=1 is dropped and sets `monitor_error`. The in-flight access continues unaffected.
- `mem_address` = `addr`, `mem_writedata` = `wdata`; both are registered.

## Timing
- Reset values: `mem_read`=0, `mem_write`=0, `mem_address`=0, `mem_writedata`=0, `MonDReg`=0, `monitor_ready`=1, `monitor_error`=0, `busy`=0, state IDLE.
- Reset mid-access: the request is deasserted at the next edge and any later `readdatavalid` is ignored.
- Pulse at edge N: request asserted from cycle N+1.
- Read with zero wait and 1-cycle read latency: `readdatavalid` arrives at N+2. `MonDReg` and `monitor_ready` update at N+3.
- Write with zero wait: `monitor_ready`=1 at N+2.
- Each wait-state cycle adds one cycle.
- A new command is accepted in the cycle `busy` returns to 0.

## Configuration
- `DEBUG_MEM_TIMEOUT_EN` defined:
  - A 16-bit counter runs in RD_REQ, RD_WAIT and WR_REQ and resets on every state entry.
  - Reaching `TIMEOUT_CYC` aborts the access: request deasserted, `monitor_error`=1, `monitor_ready`=1, `addr` and `MonDReg` unchanged, back to IDLE.
- Not defined: no counter; the block waits indefinitely.

## Test plan
- Address load + read: `take_action_ocimem_a` with `jdo[34]`=1 and address 0x10, RAM[0x10]=0xCAFEF00D -> `mem_read` at N+1, `MonDReg`=0xCAFEF00D, `monitor_ready`=1, `mem_address`=0x11.
- Write then read-next: `take_action_ocimem_b` with `jdo[34:3]`=0x12345678 at address 0xFF, 3 wait cycles -> `mem_write` held 4 cycles, address wraps to 0x00. Reload 0xFF, read -> 0x12345678.
- Overrun: `take_no_action_ocimem_a` while `busy` -> in-flight read completes normally, `monitor_error`=1. Next `take_action_ocimem_a` -> `monitor_error`=0.
- Simultaneous `take_action_ocimem_a` and `take_action_ocimem_b` -> only the address load/read executes, `monitor_error`=1.
- Reset asserted in RD_WAIT, `readdatavalid` one cycle later -> all outputs at reset values, `MonDReg`=0.
- With `DEBUG_MEM_TIMEOUT_EN` and `TIMEOUT_CYC`=20, `mem_waitrequest` stuck at 1 -> `mem_read` drops after 20 cycles, `monitor_error`=1, `monitor_ready`=1. Without the macro -> `mem_read` is still high after 1000 cycles.

Source files
------------

// File: rtl/niosii_usb_cpu_cpu_debug_mem_access.sv
// Debug-RAM access sequencer: turns debug-slave take pulses into single Avalon-MM reads/writes.
// Optional access timeout is compiled in with the DEBUG_MEM_TIMEOUT_EN macro.
module niosii_usb_cpu_cpu_debug_mem_access #(
    parameter int ADDR_W      = 8,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    input  logic [31:0]       mem_readdata,
    input  logic              mem_waitrequest,
    input  logic              mem_readdatavalid,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RD_REQ  = 2'd1,
        S_RD_WAIT = 2'd2,
        S_WR_REQ  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_addr_next;
    logic [31:0]       r_wdata;
    logic [31:0]       w_wdata_next;
    logic [31:0]       r_mon;
    logic [31:0]       w_mon_next;
    logic              r_ready;
    logic              w_ready_next;
    logic              r_error;
    logic              w_error_next;
    logic              r_mem_read;
    logic              r_mem_write;
    logic              r_busy;
    logic              w_any_take;
    logic              w_timeout;
    logic              w_unused_jdo;

    assign w_any_take   = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
    assign w_unused_jdo = ^{jdo[37:35], jdo[2:0]};

`ifdef DEBUG_MEM_TIMEOUT_EN
    logic [15:0] r_tmo_cnt;

    // Wait-cycle counter, restarted whenever the state changes.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tmo_cnt <= 16'd0;
        end else if (w_next != r_state) begin
            r_tmo_cnt <= 16'd0;
        end else if (r_state != S_IDLE) begin
            r_tmo_cnt <= r_tmo_cnt + 16'd1;
        end else begin
            r_tmo_cnt <= r_tmo_cnt;
        end
    end

    assign w_timeout = (r_tmo_cnt == 16'(TIMEOUT_CYC - 1));
`else
    logic w_unused_cfg;
    assign w_unused_cfg = (TIMEOUT_CYC > 0);
    assign w_timeout    = 1'b0;
`endif

    // Command decode and access sequencing; completion outranks a same-cycle timeout.
    always_comb begin
        w_next       = r_state;
        w_addr_next  = r_addr;
        w_wdata_next = r_wdata;
        w_mon_next   = r_mon;
        w_ready_next = r_ready;
        w_error_next = r_error;
        case (r_state)
            S_IDLE: begin
                if (take_action_ocimem_a) begin
                    w_addr_next  = jdo[ADDR_W+16:17];
                    w_error_next = take_action_ocimem_b | take_no_action_ocimem_a;
                    if (jdo[34]) begin
                        w_next       = S_RD_REQ;
                        w_ready_next = 1'b0;
                    end else begin
                        w_next = S_IDLE;
                    end
                end else if (take_action_ocimem_b) begin
                    w_wdata_next = jdo[34:3];
                    w_next       = S_WR_REQ;
                    w_ready_next = 1'b0;
                    w_error_next = r_error | take_no_action_ocimem_a;
                end else if (take_no_action_ocimem_a) begin
                    w_next       = S_RD_REQ;
                    w_ready_next = 1'b0;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_RD_REQ: begin
                w_error_next = r_error | w_any_take;
                if (!mem_waitrequest) begin
                    w_next = S_RD_WAIT;
                end else if (w_timeout) begin
                    w_next       = S_IDLE;
                    w_error_next = 1'b1;
                    w_ready_next = 1'b1;
                end else begin
                    w_next = S_RD_REQ;
                end
            end
            S_RD_WAIT: begin
                w_error_next = r_error | w_any_take;
                if (mem_readdatavalid) begin
                    w_mon_next   = mem_readdata;
                    w_ready_next = 1'b1;
                    w_addr_next  = r_addr + ADDR_W'(1);
                    w_next       = S_IDLE;
                end else if (w_timeout) begin
                    w_next       = S_IDLE;
                    w_error_next = 1'b1;
                    w_ready_next = 1'b1;
                end else begin
                    w_next = S_RD_WAIT;
                end
            end
            S_WR_REQ: begin
                w_error_next = r_error | w_any_take;
                if (!mem_waitrequest) begin
                    w_ready_next = 1'b1;
                    w_addr_next  = r_addr + ADDR_W'(1);
                    w_next       = S_IDLE;
                end else if (w_timeout) begin
                    w_next       = S_IDLE;
                    w_error_next = 1'b1;
                    w_ready_next = 1'b1;
                end else begin
                    w_next = S_WR_REQ;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // State and output registers; requests are decoded from the next state so they rise one edge after the pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_wdata     <= 32'd0;
            r_mon       <= 32'd0;
            r_ready     <= 1'b1;
            r_error     <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_addr      <= w_addr_next;
            r_wdata     <= w_wdata_next;
            r_mon       <= w_mon_next;
            r_ready     <= w_ready_next;
            r_error     <= w_error_next;
            r_mem_read  <= (w_next == S_RD_REQ);
            r_mem_write <= (w_next == S_WR_REQ);
            r_busy      <= (w_next != S_IDLE);
        end
    end

    assign mem_address   = r_addr;
    assign mem_writedata = r_wdata;
    assign mem_read      = r_mem_read;
    assign mem_write     = r_mem_write;
    assign MonDReg       = r_mon;
    assign monitor_ready = r_ready;
    assign monitor_error = r_error;
    assign busy          = r_busy;

endmodule

// File: tb/tb_niosii_usb_cpu_cpu_debug_mem_access.sv
// Bench for the debug memory access sequencer: directed vector table, random commands
// against a command-level reference model, stalled-slave and reset-mid-access sequences.
module tb_niosii_usb_cpu_cpu_debug_mem_access;

    logic        clk = 1'b0;
    logic        reset;
    logic [37:0] jdo;
    logic        ta, tn, tbw;
    logic [7:0]  mem_address;
    logic        mem_read, mem_write;
    logic [31:0] mem_writedata, mem_readdata;
    logic        mem_waitrequest, mem_readdatavalid;
    logic [31:0] MonDReg;
    logic        monitor_ready, monitor_error, busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    niosii_usb_cpu_cpu_debug_mem_access #(.ADDR_W(8), .TIMEOUT_CYC(20)) dut (
        .clk(clk), .reset(reset), .jdo(jdo),
        .take_action_ocimem_a(ta), .take_no_action_ocimem_a(tn), .take_action_ocimem_b(tbw),
        .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
        .mem_waitrequest(mem_waitrequest), .mem_readdatavalid(mem_readdatavalid),
        .MonDReg(MonDReg), .monitor_ready(monitor_ready), .monitor_error(monitor_error),
        .busy(busy)
    );

    // Avalon slave model: programmable wait states and read latency, optional stray readdatavalid.
    logic [31:0] ram [256];
    int          wait_cfg = 0, wait_left = 0, rd_lat = 1, rd_cnt = 0;
    logic [7:0]  rd_addr;
    bit          stuck = 1'b0, spurious = 1'b0;

    always @(negedge clk) begin
        if (rd_cnt == 1) begin
            mem_readdatavalid = 1'b1;
            mem_readdata      = ram[rd_addr];
        end else if (rd_cnt == 0 && spurious && $urandom_range(3) == 0) begin
            mem_readdatavalid = 1'b1;
            mem_readdata      = $urandom;
        end else begin
            mem_readdatavalid = 1'b0;
            mem_readdata      = $urandom;
        end
        if (rd_cnt > 0) rd_cnt--;
        if (stuck) begin
            mem_waitrequest = 1'b1;
        end else if (mem_read === 1'b1 || mem_write === 1'b1) begin
            if (wait_left > 0) begin
                mem_waitrequest = 1'b1;
                wait_left--;
            end else begin
                mem_waitrequest = 1'b0;
                if (mem_read) begin
                    rd_cnt  = rd_lat;
                    rd_addr = mem_address;
                end else begin
                    ram[mem_address] = mem_writedata;
                end
            end
        end else begin
            mem_waitrequest = 1'b0;
            wait_left       = wait_cfg;
        end
    end

    // Reference model: command-level view of the sequencer
    logic [7:0]  m_addr;
    logic [31:0] m_wdata, m_mon;
    logic        m_ready, m_error;
    logic [31:0] m_ram [256];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, "_mon"},   64'(MonDReg),       64'(m_mon));
        check({tag, "_ready"}, 64'(monitor_ready), 64'(m_ready));
        check({tag, "_error"}, 64'(monitor_error), 64'(m_error));
        check({tag, "_addr"},  64'(mem_address),   64'(m_addr));
        check({tag, "_wdata"}, 64'(mem_writedata), 64'(m_wdata));
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_rst_read"},  64'(mem_read),      64'd0);
        check({tag, "_rst_write"}, 64'(mem_write),     64'd0);
        check({tag, "_rst_addr"},  64'(mem_address),   64'd0);
        check({tag, "_rst_wdata"}, 64'(mem_writedata), 64'd0);
        check({tag, "_rst_mon"},   64'(MonDReg),       64'd0);
        check({tag, "_rst_ready"}, 64'(monitor_ready), 64'd1);
        check({tag, "_rst_error"}, 64'(monitor_error), 64'd0);
        check({tag, "_rst_busy"},  64'(busy),          64'd0);
    endtask

    function automatic logic [37:0] mk_a(input logic [7:0] addr, input logic rd);
        return (38'(rd) << 34) | (38'(addr) << 17);
    endfunction

    function automatic logic [37:0] mk_b(input logic [31:0] data);
        return 38'(data) << 3;
    endfunction

    function automatic logic [37:0] rnd_jdo();
        logic [63:0] t;
        t = {$urandom, $urandom};
        return t[37:0];
    endfunction

    // Apply one command to the model; reports whether it touches memory and which way.
    task automatic model_cmd(input logic a, b, n, input logic [37:0] j, input bit inject,
                             output bit access, output bit is_read);
        access  = 1'b0;
        is_read = 1'b0;
        if (a) begin
            m_addr  = j[24:17];
            m_error = b | n;
            if (j[34]) begin
                access = 1'b1; is_read = 1'b1;
            end
        end else if (b) begin
            m_wdata = j[34:3];
            m_error = m_error | n;
            access  = 1'b1;
        end else if (n) begin
            access = 1'b1; is_read = 1'b1;
        end
        if (access && is_read) begin
            m_mon = m_ram[m_addr];
            m_addr++;
            m_ready = 1'b1;
        end else if (access) begin
            m_ram[m_addr] = m_wdata;
            m_addr++;
            m_ready = 1'b1;
        end
        if (inject && access) m_error = 1'b1;
    endtask

    // Issue pulses, optionally inject a stray pulse while busy, wait (bounded) for completion.
    task automatic run_cmd(input logic a, b, n, input logic [37:0] j, input int waits, lat,
                           input bit inject, output int busy_cyc, output int req_cyc,
                           output logic [1:0] first_req);
        wait_cfg = waits;
        rd_lat   = lat;
        @(negedge clk);
        ta = a; tbw = b; tn = n; jdo = j;
        @(negedge clk);
        ta = 1'b0; tbw = 1'b0; tn = 1'b0; jdo = rnd_jdo();
        first_req = {mem_read, mem_write};
        busy_cyc  = 0;
        req_cyc   = 0;
        for (int k = 0; k < 300 && busy; k++) begin
            busy_cyc++;
            if (mem_read || mem_write) req_cyc++;
            if (inject && k == 0) begin
                case ($urandom_range(2))
                    0:       ta  = 1'b1;
                    1:       tbw = 1'b1;
                    default: tn  = 1'b1;
                endcase
            end
            @(negedge clk);
            ta = 1'b0; tbw = 1'b0; tn = 1'b0;
        end
        if (busy) check("busy_timeout", 64'(busy), 64'd0);
    endtask

    typedef struct {
        logic        a, b, n;
        logic [37:0] jdo;
        int          waits;
        logic [31:0] e_mon;
        logic        e_ready, e_err;
        logic [7:0]  e_addr;
        logic [31:0] e_wdata;
        int          e_busy, e_req;
        logic [1:0]  e_first;
    } vec_t;

    vec_t tbl [9];

    initial begin
        int          bc, rc, cyc;
        logic [1:0]  fr;
        bit          acc, isr, inj;
        logic        a, b, n;
        logic [37:0] j;
        int          w, l, r;

        tbl[0] = '{1, 0, 0, mk_a(8'h10, 1), 0, 32'hCAFEF00D, 1, 0, 8'h11, 32'h0,        2, 1, 2'b10};
        tbl[1] = '{1, 0, 0, mk_a(8'hFF, 0), 0, 32'hCAFEF00D, 1, 0, 8'hFF, 32'h0,        0, 0, 2'b00};
        tbl[2] = '{0, 1, 0, mk_b(32'h12345678), 3, 32'hCAFEF00D, 1, 0, 8'h00, 32'h12345678, 4, 4, 2'b01};
        tbl[3] = '{1, 0, 0, mk_a(8'hFF, 1), 2, 32'h12345678, 1, 0, 8'h00, 32'h12345678, 4, 3, 2'b10};
        tbl[4] = '{1, 1, 0, mk_a(8'h10, 1), 0, 32'hCAFEF00D, 1, 1, 8'h11, 32'h12345678, 2, 1, 2'b10};
        tbl[5] = '{0, 0, 1, 38'd0,          1, 32'h0BADBEEF, 1, 1, 8'h12, 32'h12345678, 3, 2, 2'b10};
        tbl[6] = '{0, 1, 1, mk_b(32'hA5A5A5A5), 0, 32'h0BADBEEF, 1, 1, 8'h13, 32'hA5A5A5A5, 1, 1, 2'b01};
        tbl[7] = '{1, 0, 0, mk_a(8'h12, 0), 0, 32'h0BADBEEF, 1, 0, 8'h12, 32'hA5A5A5A5, 0, 0, 2'b00};
        tbl[8] = '{0, 0, 1, 38'd0,          0, 32'hA5A5A5A5, 1, 0, 8'h13, 32'hA5A5A5A5, 2, 1, 2'b10};

        for (int i = 0; i < 256; i++) ram[i] = $urandom;
        ram[8'h10] = 32'hCAFEF00D;
        ram[8'h11] = 32'h0BADBEEF;
        for (int i = 0; i < 256; i++) m_ram[i] = ram[i];

        ta = 1'b0; tn = 1'b0; tbw = 1'b0; jdo = 38'd0;
        mem_waitrequest = 1'b0; mem_readdatavalid = 1'b0; mem_readdata = 32'd0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_reset_vals("init");

        for (int i = 0; i < 9; i++) begin
            run_cmd(tbl[i].a, tbl[i].b, tbl[i].n, tbl[i].jdo, tbl[i].waits, 1, 1'b0, bc, rc, fr);
            check($sformatf("vec%0d_first_req", i), 64'(fr), 64'(tbl[i].e_first));
            check($sformatf("vec%0d_busy_cyc", i), 64'(bc), 64'(tbl[i].e_busy));
            check($sformatf("vec%0d_req_cyc", i), 64'(rc), 64'(tbl[i].e_req));
            check($sformatf("vec%0d_mon", i), 64'(MonDReg), 64'(tbl[i].e_mon));
            check($sformatf("vec%0d_ready", i), 64'(monitor_ready), 64'(tbl[i].e_ready));
            check($sformatf("vec%0d_error", i), 64'(monitor_error), 64'(tbl[i].e_err));
            check($sformatf("vec%0d_addr", i), 64'(mem_address), 64'(tbl[i].e_addr));
            check($sformatf("vec%0d_wdata", i), 64'(mem_writedata), 64'(tbl[i].e_wdata));
        end
        check("ram_ff", 64'(ram[8'hFF]), 64'h12345678);

        m_addr = 8'h13; m_wdata = 32'hA5A5A5A5; m_mon = 32'hA5A5A5A5;
        m_ready = 1'b1; m_error = 1'b0;
        m_ram[8'hFF] = 32'h12345678;
        m_ram[8'h12] = 32'hA5A5A5A5;

        spurious = 1'b1;
        for (int i = 0; i < 150; i++) begin
            r = $urandom_range(9);
            a = (r < 3) || (r == 7) || (r == 9);
            b = (r == 3) || (r == 4) || (r == 8) || (r == 9) || (r == 7 && $urandom_range(1) == 1);
            n = (r == 5) || (r == 6) || (r == 8) || (r == 9) || (r == 7 && !b);
            j   = rnd_jdo();
            w   = $urandom_range(3);
            l   = $urandom_range(3, 1);
            inj = ($urandom_range(3) == 0);
            model_cmd(a, b, n, j, inj, acc, isr);
            run_cmd(a, b, n, j, w, l, inj, bc, rc, fr);
            check($sformatf("rnd%0d_busy_cyc", i), 64'(bc),
                  64'(acc ? (isr ? w + 1 + l : w + 1) : 0));
            check($sformatf("rnd%0d_req_cyc", i), 64'(rc), 64'(acc ? w + 1 : 0));
            check($sformatf("rnd%0d_first_req", i), 64'(fr),
                  64'(acc ? (isr ? 2'b10 : 2'b01) : 2'b00));
            check_state($sformatf("rnd%0d", i));
        end
        spurious = 1'b0;

        // Slave stalled forever on a read
        wait_cfg = 0;
        @(negedge clk);
        stuck = 1'b1;
        tn = 1'b1;
        @(negedge clk);
        tn = 1'b0;
`ifdef DEBUG_MEM_TIMEOUT_EN
        cyc = 0;
        for (int k = 0; k < 100 && mem_read; k++) begin
            cyc++;
            @(negedge clk);
        end
        check("tmo_req_cycles", 64'(cyc), 64'd20);
        check("tmo_busy", 64'(busy), 64'd0);
        m_error = 1'b1;
        m_ready = 1'b1;
        check_state("tmo");
        stuck = 1'b0;
`else
        repeat (1000) @(negedge clk);
        check("stall_read_held", 64'(mem_read), 64'd1);
        check("stall_busy_held", 64'(busy), 64'd1);
        stuck = 1'b0;
        for (int k = 0; k < 50 && busy; k++) @(negedge clk);
        check("stall_done", 64'(busy), 64'd0);
        m_mon = m_ram[m_addr];
        m_addr++;
        m_ready = 1'b1;
        check_state("stall");
`endif

        // Reset while waiting for read data; the late readdatavalid must be ignored
        rd_lat = 2;
        @(negedge clk);
        tn = 1'b1;
        @(negedge clk);
        tn = 1'b0;
        check("rstmid_read_req", 64'(mem_read), 64'd1);
        @(negedge clk);
        check("rstmid_in_wait", 64'({busy, mem_read}), 64'b10);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_reset_vals("rstmid");
        repeat (3) @(negedge clk);
        check("rstmid_mon_after", 64'(MonDReg), 64'd0);

        m_addr = 8'h00; m_wdata = 32'd0; m_mon = 32'd0; m_ready = 1'b1; m_error = 1'b0;
        model_cmd(1'b0, 1'b0, 1'b1, 38'd0, 1'b0, acc, isr);
        run_cmd(1'b0, 1'b0, 1'b1, 38'd0, 1, 1, 1'b0, bc, rc, fr);
        check("post_rst_busy_cyc", 64'(bc), 64'd3);
        check_state("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
